// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline: word width, reset/bubble
// constants and the IF/ID pipeline register payload.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic            valid;
        logic            fault;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic stall/flush pipeline register; flush and reset load BUBBLE,
// stall holds the current contents.
module if_id_reg #(
    parameter type T      = core_pkg::if_id_t,
    parameter T    BUBBLE = T'(0)
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic flush,
    input  T     d,
    output T     q
);

    T reg_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            reg_q <= BUBBLE;
        end else if (!stall) begin
            reg_q <= d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, fetch fault detection and the
// IF/ID pipeline register feeding decode.
module fetch_stage
    import core_pkg::if_id_t;
    import core_pkg::XLEN;
#(
    parameter logic [31:0] RESET_PC   = core_pkg::RESET_PC,
    parameter int unsigned IMEM_WORDS = 64,
    parameter logic [31:0] NOP_INSTR  = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] target_e,
    output logic [XLEN-1:0] imem_a,
    input  logic [XLEN-1:0] imem_rd,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d,
    output logic            fetch_fault_d
);

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:   NOP_INSTR,
        pc:      '0,
        pcplus4: '0,
        valid:   1'b0,
        fault:   1'b0
    };

    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [XLEN-1:0] pcplus4_f;
    logic            misalign_q, misalign_d;
    logic            fault_f;
    logic            if_id_flush;
    logic            if_id_load;
    if_id_t          if_id_d, if_id_q;

    assign pcplus4_f   = pc_f_q + 32'd4;
    assign imem_a      = pc_f_q;
    assign if_id_flush = flush_d | redirect_e;
    assign if_id_load  = !if_id_flush && !stall_d;

    always_comb begin
        pc_f_d = pcplus4_f;
        if (redirect_e) begin
            pc_f_d = {target_e[XLEN-1:2], 2'b00};
        end else if (stall_f) begin
            pc_f_d = pc_f_q;
        end
    end

    // A misaligned redirect target is forced aligned, so remember the
    // misalignment until the first fetch at the new PC reaches IF/ID.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_e) begin
            misalign_d = (target_e[1:0] != 2'b00);
        end else if (if_id_load) begin
            misalign_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q     <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_f_q     <= pc_f_d;
            misalign_q <= misalign_d;
        end
    end

    assign fault_f = (pc_f_q[1:0] != 2'b00)
                   | ({2'b00, pc_f_q[XLEN-1:2]} >= 32'(IMEM_WORDS))
                   | misalign_q;

    always_comb begin
        if_id_d         = IF_ID_BUBBLE;
        if_id_d.instr   = imem_rd;
        if_id_d.pc      = pc_f_q;
        if_id_d.pcplus4 = pcplus4_f;
        if_id_d.valid   = 1'b1;
        if_id_d.fault   = fault_f;
    end

    if_id_reg #(
        .T      (if_id_t),
        .BUBBLE (IF_ID_BUBBLE)
    ) u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .stall (stall_d),
        .flush (if_id_flush),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign instr_d       = if_id_q.instr;
    assign pc_d          = if_id_q.pc;
    assign pcplus4_d     = if_id_q.pcplus4;
    assign valid_d       = if_id_q.valid;
    assign fetch_fault_d = if_id_q.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a combinational instruction
// memory model holding a small known program.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_f = 1'b0;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic        redirect_e = 1'b0;
    logic [31:0] target_e = 32'h0;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        fetch_fault_d;

    logic [31:0] prog [64];
    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(
        .RESET_PC   (32'h0),
        .IMEM_WORDS (64),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .redirect_e    (redirect_e),
        .target_e      (target_e),
        .imem_a        (imem_a),
        .imem_rd       (imem_rd),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .pcplus4_d     (pcplus4_d),
        .valid_d       (valid_d),
        .fetch_fault_d (fetch_fault_d)
    );

    always #5 clk = ~clk;

    // Out-of-range reads return a recognisable tag of the low address bits.
    always_comb begin
        if (imem_a[31:8] == 24'h0) imem_rd = prog[imem_a[7:2]];
        else                       imem_rd = 32'hBAD0_0000 | {16'h0, imem_a[15:0]};
    end

    task automatic step();
        @(posedge clk);
        #1;
        $display("[TB] t=%0t imem_a=%h instr_d=%h pc_d=%h pc4_d=%h v=%b f=%b",
                 $time, imem_a, instr_d, pc_d, pcplus4_d, valid_d, fetch_fault_d);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_tests++; if (imem_a !== 32'h0) begin n_fail++; $display("FAIL reset_imem_a: got %h want %h", imem_a, 32'h0); end
        n_tests++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_d); end
        n_tests++; if (instr_d !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr_d, NOP); end
        n_tests++; if (pc_d !== 32'h0 || pcplus4_d !== 32'h0 || fetch_fault_d !== 1'b0) begin
            n_fail++; $display("FAIL reset_pc: got pc=%h pc4=%h f=%b want 0/0/0", pc_d, pcplus4_d, fetch_fault_d); end
        reset = 1'b0;
        step();
        n_tests++; if (instr_d !== 32'h00500113 || pc_d !== 32'h0 || pcplus4_d !== 32'h4 || valid_d !== 1'b1) begin
            n_fail++; $display("FAIL first_fetch: got %h/%h/%h/%b want 00500113/0/4/1", instr_d, pc_d, pcplus4_d, valid_d); end
        step();
        n_tests++; if (instr_d !== 32'h00C00193 || pc_d !== 32'h4 || imem_a !== 32'h8) begin
            n_fail++; $display("FAIL second_fetch: got %h/%h a=%h want 00C00193/4 a=8", instr_d, pc_d, imem_a); end
    endtask

    task automatic test_stall();
        stall_f = 1'b1;
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++; if (imem_a !== 32'h8 || pc_d !== 32'h4 || instr_d !== 32'h00C00193) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got a=%h pc=%h i=%h want 8/4/00C00193", i, imem_a, pc_d, instr_d); end
        end
        stall_f = 1'b0;
        stall_d = 1'b0;
        step();
        n_tests++; if (pc_d !== 32'h8 || instr_d !== 32'hFF718393 || imem_a !== 32'hC) begin
            n_fail++; $display("FAIL stall_release: got pc=%h i=%h a=%h want 8/FF718393/C", pc_d, instr_d, imem_a); end
    endtask

    task automatic test_mid_reset();
        step();
        n_tests++; if (imem_a !== 32'h10) begin n_fail++; $display("FAIL pre_reset_pc: got %h want 10", imem_a); end
        reset = 1'b1;
        step();
        n_tests++; if (imem_a !== 32'h0 || valid_d !== 1'b0 || instr_d !== NOP) begin
            n_fail++; $display("FAIL mid_reset: got a=%h v=%b i=%h want 0/0/%h", imem_a, valid_d, instr_d, NOP); end
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic test_redirect_stall();
        stall_f = 1'b1;
        redirect_e = 1'b1;
        target_e = 32'h38;
        step();
        stall_f = 1'b0;
        redirect_e = 1'b0;
        n_tests++; if (imem_a !== 32'h38 || valid_d !== 1'b0 || instr_d !== NOP) begin
            n_fail++; $display("FAIL redirect_bubble: got a=%h v=%b i=%h want 38/0/%h", imem_a, valid_d, instr_d, NOP); end
        step();
        n_tests++; if (instr_d !== 32'h06002103 || pc_d !== 32'h38 || valid_d !== 1'b1 || fetch_fault_d !== 1'b0) begin
            n_fail++; $display("FAIL redirect_target: got %h/%h/%b/%b want 06002103/38/1/0", instr_d, pc_d, valid_d, fetch_fault_d); end
    endtask

    task automatic test_misaligned();
        redirect_e = 1'b1;
        target_e = 32'h22;
        step();
        redirect_e = 1'b0;
        n_tests++; if (imem_a !== 32'h20) begin n_fail++; $display("FAIL misalign_addr: got %h want 20", imem_a); end
        step();
        n_tests++; if (pc_d !== 32'h20 || fetch_fault_d !== 1'b1 || instr_d !== 32'hA000_0008) begin
            n_fail++; $display("FAIL misalign_fault: got pc=%h f=%b i=%h want 20/1/A0000008", pc_d, fetch_fault_d, instr_d); end
        step();
        n_tests++; if (pc_d !== 32'h24 || fetch_fault_d !== 1'b0) begin
            n_fail++; $display("FAIL misalign_clear: got pc=%h f=%b want 24/0", pc_d, fetch_fault_d); end
    endtask

    task automatic test_range();
        redirect_e = 1'b1;
        target_e = 32'hF8;
        step();
        redirect_e = 1'b0;
        step();
        step();
        n_tests++; if (pc_d !== 32'hFC || fetch_fault_d !== 1'b0 || instr_d !== 32'hA000_003F) begin
            n_fail++; $display("FAIL range_last: got pc=%h f=%b i=%h want FC/0/A000003F", pc_d, fetch_fault_d, instr_d); end
        step();
        n_tests++; if (pc_d !== 32'h100 || pcplus4_d !== 32'h104 || fetch_fault_d !== 1'b1 || valid_d !== 1'b1 || instr_d !== 32'hBAD0_0100) begin
            n_fail++; $display("FAIL range_over: got pc=%h pc4=%h f=%b v=%b i=%h want 100/104/1/1/BAD00100",
                               pc_d, pcplus4_d, fetch_fault_d, valid_d, instr_d); end
    endtask

    task automatic test_wrap_and_flush();
        redirect_e = 1'b1;
        target_e = 32'hFFFF_FFFC;
        step();
        redirect_e = 1'b0;
        step();
        n_tests++; if (pc_d !== 32'hFFFF_FFFC || pcplus4_d !== 32'h0 || imem_a !== 32'h0 || fetch_fault_d !== 1'b1) begin
            n_fail++; $display("FAIL wrap: got pc=%h pc4=%h a=%h f=%b want FFFFFFFC/0/0/1", pc_d, pcplus4_d, imem_a, fetch_fault_d); end
        flush_d = 1'b1;
        step();
        flush_d = 1'b0;
        n_tests++; if (valid_d !== 1'b0 || instr_d !== NOP || pc_d !== 32'h0 || imem_a !== 32'h4) begin
            n_fail++; $display("FAIL flush: got v=%b i=%h pc=%h a=%h want 0/%h/0/4", valid_d, instr_d, pc_d, imem_a, NOP); end
        step();
        n_tests++; if (valid_d !== 1'b1 || pc_d !== 32'h4 || instr_d !== 32'h00C00193 || fetch_fault_d !== 1'b0) begin
            n_fail++; $display("FAIL after_flush: got v=%b pc=%h i=%h f=%b want 1/4/00C00193/0", valid_d, pc_d, instr_d, fetch_fault_d); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prog[i] = 32'hA000_0000 | i;
        prog[0]  = 32'h00500113;
        prog[1]  = 32'h00C00193;
        prog[2]  = 32'hFF718393;
        prog[14] = 32'h06002103;

        test_reset();
        test_stall();
        test_mid_reset();
        test_redirect_stall();
        test_misaligned();
        test_range();
        test_wrap_and_flush();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
